// File: rtl/cfg_pkg.sv
// cfg_pkg: shared constants and state type for the configuration loader
package cfg_pkg;
   localparam logic [7:0] SYNC_WORD = 8'hA5;
   localparam int CHK_LANES = 8;
   typedef enum logic [1:0] {HUNT, LOAD, CHECK, COMMIT} cfg_state_t;
endpackage

// File: rtl/cfg_chk8.sv
// cfg_chk8: 8-lane XOR accumulator; each enabled bit folds into the lane picked by lane
module cfg_chk8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       data,
   input  logic [2:0] lane,
   output logic [7:0] chk
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) chk <= '0;
      else if (clr) chk <= '0;
      else if (en) chk[lane] <= chk[lane] ^ data;
endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: hunts a sync byte, shifts a framed payload into a shadow register and
// commits it to cfg_out only when the 8-lane XOR checksum matches
module cfg_loader
   import cfg_pkg::*;
#(
   parameter int CFG_SIZE   = 18,
   parameter int NUM_BLOCKS = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           bs_valid,
   input  logic                           bs_data,
   output logic                           bs_ready,
   input  logic                           abort,
   output logic [NUM_BLOCKS*CFG_SIZE-1:0] cfg_out,
   output logic                           cfg_valid,
   output logic                           done,
   output logic                           err
);
   localparam int P  = NUM_BLOCKS * CFG_SIZE;
   localparam int CW = $clog2(P);
   cfg_state_t state, state_nx;
   logic [6:0]    sync;
   logic [7:0]    rx, chk;
   logic [CW-1:0] cnt;
   logic [P-1:0]  shadow;
   logic          acc, sync_hit, last_pay, last_chk, match;
   assign acc      = bs_valid && bs_ready && !abort;
   assign sync_hit = {sync, bs_data} == SYNC_WORD;
   assign last_pay = cnt == CW'(P - 1);
   assign last_chk = cnt == CW'(CHK_LANES - 1);
   assign match    = rx == chk;
   cfg_chk8 u_chk (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (abort || state == HUNT),
      .en   (acc && state == LOAD),
      .data (bs_data),
      .lane (cnt[2:0]),
      .chk  (chk)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= HUNT;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (abort) state_nx = HUNT;
      else
         case (state)
            HUNT:   if (acc && sync_hit) state_nx = LOAD;
            LOAD:   if (acc && last_pay) state_nx = CHECK;
            CHECK:  if (acc && last_chk) state_nx = COMMIT;
            COMMIT: state_nx = HUNT;
         endcase
   end
   always_comb bs_ready = rst_n && state != COMMIT;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync      <= '0;
         rx        <= '0;
         cnt       <= '0;
         shadow    <= '0;
         cfg_out   <= '0;
         cfg_valid <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (abort) begin
            sync <= '0;
            rx   <= '0;
            cnt  <= '0;
         end else
            case (state)
               HUNT: if (acc) begin
                  sync <= sync_hit ? '0 : {sync[5:0], bs_data};
                  cnt  <= '0;
               end
               LOAD: if (acc) begin
                  shadow[cnt] <= bs_data;
                  cnt         <= last_pay ? '0 : cnt + CW'(1);
               end
               CHECK: if (acc) begin
                  rx  <= {bs_data, rx[7:1]};
                  cnt <= cnt + CW'(1);
               end
               COMMIT: begin
                  cnt <= '0;
                  if (match) begin
                     cfg_out   <= shadow;
                     cfg_valid <= 1'b1;
                     done      <= 1'b1;
                  end else err <= 1'b1;
               end
            endcase
      end
endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: randomized frames checked against a bit-stream parsing model
module tb_cfg_loader;
   localparam int P = 36;
   logic clk = 0, rst_n = 0, bs_valid = 0, bs_data = 0, abort = 0;
   logic bs_ready, cfg_valid, done, err;
   logic [P-1:0] cfg_out;
   int checks = 0, failures = 0, done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
   logic [P-1:0] exp_cfg = '0;
   logic exp_valid = 0;
   logic q[$];

   cfg_loader #(.CFG_SIZE(18), .NUM_BLOCKS(2)) dut (
      .clk(clk), .rst_n(rst_n), .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready),
      .abort(abort), .cfg_out(cfg_out), .cfg_valid(cfg_valid), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
   end
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   function automatic logic [7:0] calc_chk(input logic [P-1:0] p);
      logic [7:0] c = '0;
      for (int k = 0; k < P; k++) c[k % 8] ^= p[k];
      return c;
   endfunction

   task automatic add_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) q.push_back(v[i]);
   endtask

   task automatic add_frame(input logic [P-1:0] p, input logic [7:0] c);
      add_byte(8'hA5);
      for (int k = 0; k < P; k++) q.push_back(p[k]);
      for (int i = 0; i < 8; i++) q.push_back(c[i]);
   endtask

   function automatic logic [P-1:0] rand_pay();
      logic [63:0] r = {$urandom, $urandom};
      return r[P-1:0];
   endfunction

   // Parses the queued bit stream as the loader should and updates expectations
   task automatic model_run();
      int i = 0;
      logic [7:0] w, rc;
      logic [P-1:0] p;
      while (i < q.size()) begin
         w = '0;
         while (i < q.size() && w != 8'hA5) begin
            w = {w[6:0], q[i]};
            i++;
         end
         if (w != 8'hA5 || i + P + 8 > q.size()) break;
         for (int k = 0; k < P; k++) p[k] = q[i + k];
         i += P;
         for (int j = 0; j < 8; j++) rc[j] = q[i + j];
         i += 8;
         if (rc == calc_chk(p)) begin
            exp_cfg = p;
            exp_valid = 1;
            exp_done++;
         end else exp_err++;
      end
   endtask

   task automatic send_stream(input bit gaps);
      bit ok;
      for (int i = 0; i < q.size(); i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            bs_valid = 0;
            repeat ($urandom_range(1, 3)) begin
               bs_data = 1'($urandom);
               @(posedge clk); #1;
            end
         end
         bs_valid = 1;
         bs_data = q[i];
         ok = 0;
         for (int t = 0; t < 8 && !ok; t++) begin
            ok = bs_ready;
            @(posedge clk); #1;
         end
         if (!ok) begin
            checks++;
            failures++;
            $display("FAIL stall beat=%0d bs_ready=%b required=1", i, bs_ready);
         end
      end
      bs_valid = 0;
      q.delete();
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cfg_out !== '0 || cfg_valid !== 0 || bs_ready !== 0 || done !== 0 || err !== 0) begin
         failures++;
         $display("FAIL reset cfg=%h valid=%b ready=%b done=%b err=%b required 0", cfg_out, cfg_valid, bs_ready, done, err);
      end
      rst_n = 1;
      #1;
      checks++;
      if (bs_ready !== 1) begin
         failures++;
         $display("FAIL reset_release bs_ready=%b required=1", bs_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_good_ones();
      int d0 = done_cnt;
      add_frame('1, 8'h0F);
      model_run();
      send_stream(0);
      checks++;
      if (bs_ready !== 0 || done !== 0 || cfg_valid !== 0) begin
         failures++;
         $display("FAIL commit_cycle ready=%b done=%b valid=%b required 0,0,0", bs_ready, done, cfg_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1 || cfg_valid !== 1 || cfg_out !== 36'hF_FFFF_FFFF) begin
         failures++;
         $display("FAIL good_commit done=%b valid=%b cfg=%h required 1,1,fffffffff", done, cfg_valid, cfg_out);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 0 || done_cnt - d0 !== 1) begin
         failures++;
         $display("FAIL good_pulse done=%b pulses=%0d required 0,1", done, done_cnt - d0);
      end
   endtask

   task automatic test_bad_chk();
      int d0 = done_cnt, e0 = err_cnt;
      add_frame({18'h3FFFF, 18'h00155}, 8'h00);
      model_run();
      send_stream(0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
         failures++;
         $display("FAIL bad_chk err_pulses=%0d done_pulses=%0d required 1,0", err_cnt - e0, done_cnt - d0);
      end
      checks++;
      if (cfg_out !== exp_cfg || cfg_valid !== 1) begin
         failures++;
         $display("FAIL bad_chk_hold cfg=%h valid=%b required %h,1", cfg_out, cfg_valid, exp_cfg);
      end
   endtask

   task automatic test_hunt_gaps();
      int d0 = done_cnt, e0 = err_cnt, md0 = exp_done, me0 = exp_err;
      logic [P-1:0] p = rand_pay();
      p[0] = ~exp_cfg[0];
      add_byte(8'h5A);
      q.push_back(1); q.push_back(0); q.push_back(1); q.push_back(0);
      add_frame(p, calc_chk(p));
      model_run();
      send_stream(1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done_cnt - d0 !== exp_done - md0 || err_cnt - e0 !== exp_err - me0) begin
         failures++;
         $display("FAIL hunt_pulses done=%0d err=%0d required %0d,%0d", done_cnt - d0, err_cnt - e0, exp_done - md0, exp_err - me0);
      end
      checks++;
      if (cfg_out !== exp_cfg) begin
         failures++;
         $display("FAIL hunt_cfg got=%h required=%h", cfg_out, exp_cfg);
      end
      checks++;
      if (cfg_out[0] !== p[0]) begin
         failures++;
         $display("FAIL hunt_bit0 got=%b required=%b", cfg_out[0], p[0]);
      end
   endtask

   task automatic test_abort();
      int d0 = done_cnt, e0 = err_cnt;
      logic [P-1:0] p = rand_pay();
      add_byte(8'hA5);
      for (int k = 0; k < 20; k++) q.push_back(p[k]);
      send_stream(0);
      bs_valid = 1;
      bs_data = 1'($urandom);
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      bs_valid = 0;
      checks++;
      if (bs_ready !== 1) begin
         failures++;
         $display("FAIL abort_ready got=%b required=1", bs_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (done_cnt !== d0 || err_cnt !== e0 || cfg_out !== exp_cfg) begin
         failures++;
         $display("FAIL abort_quiet done=%0d err=%0d cfg=%h required 0,0,%h", done_cnt - d0, err_cnt - e0, cfg_out, exp_cfg);
      end
      p = rand_pay();
      add_frame(p, calc_chk(p));
      model_run();
      send_stream(1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cfg_out !== p || done_cnt - d0 !== 1 || err_cnt !== e0) begin
         failures++;
         $display("FAIL abort_recover cfg=%h done=%0d err=%0d required %h,1,0", cfg_out, done_cnt - d0, err_cnt - e0, p);
      end
   endtask

   task automatic test_back_to_back();
      int d0 = done_cnt, e0 = err_cnt, md0 = exp_done, me0 = exp_err;
      logic [P-1:0] p;
      logic [7:0] c;
      for (int f = 0; f < 8; f++) begin
         p = rand_pay();
         c = calc_chk(p);
         if ($urandom_range(0, 2) == 0) c[$urandom_range(0, 7)] ^= 1'b1;
         add_frame(p, c);
      end
      model_run();
      send_stream(0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done_cnt - d0 !== exp_done - md0 || err_cnt - e0 !== exp_err - me0) begin
         failures++;
         $display("FAIL b2b_pulses done=%0d err=%0d required %0d,%0d", done_cnt - d0, err_cnt - e0, exp_done - md0, exp_err - me0);
      end
      checks++;
      if (cfg_out !== exp_cfg || cfg_valid !== exp_valid) begin
         failures++;
         $display("FAIL b2b_cfg cfg=%h valid=%b required %h,%b", cfg_out, cfg_valid, exp_cfg, exp_valid);
      end
   endtask

   task automatic test_reset_mid_check();
      int d0 = done_cnt, e0 = err_cnt;
      logic [P-1:0] p = rand_pay();
      add_byte(8'hA5);
      for (int k = 0; k < P; k++) q.push_back(p[k]);
      for (int i = 0; i < 4; i++) q.push_back(1'($urandom));
      send_stream(0);
      #2;
      rst_n = 0;
      #1;
      checks++;
      if (cfg_out !== '0 || cfg_valid !== 0 || bs_ready !== 0 || done !== 0 || err !== 0) begin
         failures++;
         $display("FAIL async_reset cfg=%h valid=%b ready=%b done=%b err=%b required 0", cfg_out, cfg_valid, bs_ready, done, err);
      end
      exp_cfg = '0;
      exp_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done_cnt !== d0 || err_cnt !== e0 || bs_ready !== 1 || cfg_valid !== 0) begin
         failures++;
         $display("FAIL reset_quiet done=%0d err=%0d ready=%b valid=%b required 0,0,1,0", done_cnt - d0, err_cnt - e0, bs_ready, cfg_valid);
      end
   endtask

   initial begin
      test_reset();
      test_good_ones();
      test_bad_chk();
      test_hunt_gaps();
      test_abort();
      test_back_to_back();
      test_reset_mid_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
